tea_engine: RTL and testbench

//  Iterative TEA block cipher core: enciphers or deciphers one 64-bit block (iV0,iV1) under a 128-bit key.
//  Key words are fetched one at a time through an address/data port from an external key store.

---
 rtl/tea_pkg.sv | 26 ++
 rtl/tea_round_fn.sv | 14 +
 rtl/tea_engine.sv | 141 ++++++++++++++
 tb/tb_tea_engine.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// Shared constants for the TEA engine: FSM state encoding, key word indices,
// the default key-schedule constant and the decipher starting-sum helper.
package tea_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_KA   = 3'd2;
   localparam logic [2:0] ST_KB   = 3'd3;
   localparam logic [2:0] ST_KC   = 3'd4;
   localparam logic [2:0] ST_KD   = 3'd5;
   localparam logic [2:0] ST_DONE = 3'd6;

   localparam logic [1:0] KEY_K0 = 2'd0;
   localparam logic [1:0] KEY_K1 = 2'd1;
   localparam logic [1:0] KEY_K2 = 2'd2;
   localparam logic [1:0] KEY_K3 = 2'd3;

   localparam logic [31:0] TEA_DEFAULT_DELTA = 32'h9e3779b9;

   // Full-width product; the caller truncates to its word size (mod 2^WS).
   function automatic logic [63:0] delta_times_rounds(input logic [63:0] delta,
                                                      input logic [63:0] rounds);
      return delta * rounds;
   endfunction

endpackage

// File: rtl/tea_round_fn.sv
// TEA mixing function F(x,ka,kb,s) = ((x<<4)+ka) ^ (x+s) ^ ((x>>5)+kb), all mod 2^WORD_SIZE.
module tea_round_fn #(
   parameter int unsigned WORD_SIZE = 32
) (
   input  logic [WORD_SIZE-1:0] x,
   input  logic [WORD_SIZE-1:0] ka,
   input  logic [WORD_SIZE-1:0] kb,
   input  logic [WORD_SIZE-1:0] sum,
   output logic [WORD_SIZE-1:0] f
);

   assign f = ((x << 4) + ka) ^ (x + sum) ^ ((x >> 5) + kb);

endmodule

// File: rtl/tea_engine.sv
// Iterative TEA encipher/decipher core fetching key words through an address/data port.
// Optional macro TEA_BUSY_EN adds the oBusy output (high from LOAD through KD).
module tea_engine
   import tea_pkg::*;
#(
   parameter int unsigned           WORD_SIZE    = 32,
   parameter logic [WORD_SIZE-1:0]  DELTA        = WORD_SIZE'(TEA_DEFAULT_DELTA),
   parameter int unsigned           ROUND_NUMBER = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 iStartCipher,
   input  logic                 iStartDecipher,
   input  logic [WORD_SIZE-1:0] iV0,
   input  logic [WORD_SIZE-1:0] iV1,
   input  logic [WORD_SIZE-1:0] iKey_sub_i,
   output logic [1:0]           oKey_address,
   output logic [WORD_SIZE-1:0] oC0,
   output logic [WORD_SIZE-1:0] oC1,
   output logic                 oDone,
`ifdef TEA_BUSY_EN
   output logic                 oBusy,
`endif
   output logic [2:0]           fsm_state
);

   localparam logic [WORD_SIZE-1:0] SUM_INIT =
      WORD_SIZE'(delta_times_rounds(64'(DELTA), 64'(ROUND_NUMBER)));
   localparam logic [31:0] LAST_ROUND = 32'(ROUND_NUMBER - 1);

   logic [2:0]           state;
   logic                 decipher;
   logic [WORD_SIZE-1:0] v0;
   logic [WORD_SIZE-1:0] v1;
   logic [WORD_SIZE-1:0] sum;
   logic [WORD_SIZE-1:0] key_a;
   logic [31:0]          round_cnt;
   logic [1:0]           key_addr;

   logic                 tgt_is_v0;
   logic [WORD_SIZE-1:0] f_x;
   logic [WORD_SIZE-1:0] f_tgt;
   logic [WORD_SIZE-1:0] f;
   logic [WORD_SIZE-1:0] upd;

   // Cipher updates v0 in KB and v1 in KD; decipher does the reverse.
   // F always reads the half that is not being written.
   always_comb begin
      tgt_is_v0 = ((state == ST_KB) != decipher);
      f_x       = v0;
      f_tgt     = v1;
      if (tgt_is_v0) begin
         f_x   = v1;
         f_tgt = v0;
      end
      upd = decipher ? (f_tgt - f) : (f_tgt + f);
   end

   tea_round_fn #(.WORD_SIZE(WORD_SIZE)) u_round_fn (
      .x   (f_x),
      .ka  (key_a),
      .kb  (iKey_sub_i),
      .sum (sum),
      .f   (f)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         decipher  <= 1'b0;
         v0        <= '0;
         v1        <= '0;
         sum       <= '0;
         key_a     <= '0;
         round_cnt <= '0;
         key_addr  <= KEY_K0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (iStartCipher || iStartDecipher) begin
                  decipher <= !iStartCipher;
                  state    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               v0        <= iV0;
               v1        <= iV1;
               sum       <= decipher ? SUM_INIT : '0;
               round_cnt <= '0;
               key_addr  <= decipher ? KEY_K2 : KEY_K0;
               state     <= ST_KA;
            end
            ST_KA: begin
               key_a    <= iKey_sub_i;
               // Encipher advances the sum before the round uses it.
               if (!decipher) sum <= sum + DELTA;
               key_addr <= decipher ? KEY_K3 : KEY_K1;
               state    <= ST_KB;
            end
            ST_KB: begin
               if (tgt_is_v0) v0 <= upd;
               else           v1 <= upd;
               key_addr <= decipher ? KEY_K0 : KEY_K2;
               state    <= ST_KC;
            end
            ST_KC: begin
               key_a    <= iKey_sub_i;
               key_addr <= decipher ? KEY_K1 : KEY_K3;
               state    <= ST_KD;
            end
            ST_KD: begin
               if (tgt_is_v0) v0 <= upd;
               else           v1 <= upd;
               // Decipher retires the sum only after both halves used it.
               if (decipher) sum <= sum - DELTA;
               if (round_cnt == LAST_ROUND) begin
                  state <= ST_DONE;
               end else begin
                  round_cnt <= round_cnt + 32'd1;
                  key_addr  <= decipher ? KEY_K2 : KEY_K0;
                  state     <= ST_KA;
               end
            end
            ST_DONE: begin
               if (!iStartCipher && !iStartDecipher) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign oC0          = v0;
   assign oC1          = v1;
   assign oKey_address = key_addr;
   assign oDone        = (state == ST_DONE);
   assign fsm_state    = state;
`ifdef TEA_BUSY_EN
   assign oBusy        = (state != ST_IDLE) && (state != ST_DONE);
`endif

endmodule

// File: tb/tb_tea_engine.sv
// Scoreboard bench for tea_engine: reference TEA model, randomized blocks/keys,
// monitor pops expected results on each rising oDone.
module tb_tea_engine;
   import tea_pkg::*;

   localparam logic [31:0] DELTA   = 32'h9e3779b9;
   localparam int          LATENCY = 129;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_c;
   logic        start_d;
   logic [31:0] v0_in;
   logic [31:0] v1_in;
   logic [31:0] key_word;
   logic [1:0]  key_addr;
   logic [31:0] c0;
   logic [31:0] c1;
   logic        done;
   logic [2:0]  fsm_state;
`ifdef TEA_BUSY_EN
   logic        busy;
`endif

   logic [31:0] key_mem[4];
   logic [63:0] exp_q[$];
   int          exp_cyc_q[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic        prev_done = 1'b0;
   logic [63:0] mon_e;
   int          mon_ec;

   tea_engine dut (
      .clk            (clk),
      .rst            (rst),
      .iStartCipher   (start_c),
      .iStartDecipher (start_d),
      .iV0            (v0_in),
      .iV1            (v1_in),
      .iKey_sub_i     (key_word),
      .oKey_address   (key_addr),
      .oC0            (c0),
      .oC1            (c1),
      .oDone          (done),
`ifdef TEA_BUSY_EN
      .oBusy          (busy),
`endif
      .fsm_state      (fsm_state)
   );

   // Clock / cycle counter / key store
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign key_word = key_mem[key_addr];

   // Reference model: textbook TEA loops
   function automatic logic [63:0] tea_enc(input logic [63:0] blk);
      logic [31:0] y, z, s;
      y = blk[63:32];
      z = blk[31:0];
      s = 32'd0;
      for (int r = 0; r < 32; r++) begin
         s = s + DELTA;
         y = y + (((z << 4) + key_mem[0]) ^ (z + s) ^ ((z >> 5) + key_mem[1]));
         z = z + (((y << 4) + key_mem[2]) ^ (y + s) ^ ((y >> 5) + key_mem[3]));
      end
      return {y, z};
   endfunction

   function automatic logic [63:0] tea_dec(input logic [63:0] blk);
      logic [31:0] y, z, s;
      y = blk[63:32];
      z = blk[31:0];
      s = DELTA * 32'd32;
      for (int r = 0; r < 32; r++) begin
         z = z - (((y << 4) + key_mem[2]) ^ (y + s) ^ ((y >> 5) + key_mem[3]));
         y = y - (((z << 4) + key_mem[0]) ^ (z + s) ^ ((z >> 5) + key_mem[1]));
         s = s - DELTA;
      end
      return {y, z};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!rst && done && !prev_done) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got result %h with nothing expected", {c0, c1});
         end else begin
            mon_e = exp_q.pop_front();
            check("result", {c0, c1}, mon_e);
            if (exp_cyc_q.size() > 0) begin
               mon_ec = exp_cyc_q.pop_front();
               check("latency_cycle", 64'(cyc), 64'(mon_ec));
            end
         end
      end
      prev_done = done;
   end

   // Driver tasks
   task automatic start_op(input logic sc, input logic sd, input logic [63:0] blk,
                           input logic [63:0] e);
      @(negedge clk);
      start_c = sc;
      start_d = sd;
      v0_in   = blk[63:32];
      v1_in   = blk[31:0];
      @(posedge clk);
      #1;
      exp_q.push_back(e);
      exp_cyc_q.push_back(cyc + LATENCY);
      @(posedge clk);
      #1;
      v0_in = $urandom;
      v1_in = $urandom;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: got done=%0b expected 1 within 400 cycles", done);
      end
   endtask

   task automatic release_starts(input logic [63:0] e);
      @(negedge clk);
      start_c = 1'b0;
      start_d = 1'b0;
      @(negedge clk);
      check("done_drop", 64'(done), 64'd0);
      check("hold_after_idle", {c0, c1}, e);
      @(negedge clk);
   endtask

   task automatic check_addr_seq(input int first);
      logic [1:0] ea;
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         ea = 2'((j + first) % 4);
         check("key_addr_seq", 64'(key_addr), 64'(ea));
`ifdef TEA_BUSY_EN
         check("busy_running", 64'(busy), 64'd1);
`endif
      end
   endtask

   task automatic run_op(input logic sc, input logic sd, input logic [63:0] blk,
                         input logic [63:0] e);
      start_op(sc, sd, blk, e);
      wait_done();
      release_starts(e);
   endtask

   // Main sequence
   initial begin
      logic [63:0] e;
      logic [63:0] blk;
      logic        seen;
      logic        dropped;
      logic        sc;

      rst     = 1'b1;
      start_c = 1'b0;
      start_d = 1'b0;
      v0_in   = '0;
      v1_in   = '0;
      for (int i = 0; i < 4; i++) key_mem[i] = 32'd0;
      repeat (3) @(negedge clk);
      check("reset_c", {c0, c1}, 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_addr", 64'(key_addr), 64'd0);
      check("reset_state", 64'(fsm_state), 64'(ST_IDLE));
`ifdef TEA_BUSY_EN
      check("reset_busy", 64'(busy), 64'd0);
`endif
      rst = 1'b0;
      @(negedge clk);

      // Known-answer vectors, zero key
      run_op(1'b1, 1'b0, 64'h0, 64'h41ea3a0a_94baa940);
      run_op(1'b0, 1'b1, 64'h41ea3a0a_94baa940, 64'h0);

      // Fixed key round trip
      key_mem[0] = 32'h132acf42;
      key_mem[1] = 32'h234acb45;
      key_mem[2] = 32'h3235acbe;
      key_mem[3] = 32'h4533f235;
      e = tea_enc(64'h3d45f7a7_235fcb21);
      run_op(1'b1, 1'b0, 64'h3d45f7a7_235fcb21, e);
      run_op(1'b0, 1'b1, e, 64'h3d45f7a7_235fcb21);

      // Start held high: one operation, done stays high
      blk = {$urandom, $urandom};
      e   = tea_enc(blk);
      start_op(1'b1, 1'b0, blk, e);
      seen    = 1'b0;
      dropped = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (seen && !done) dropped = 1'b1;
         if (done) seen = 1'b1;
      end
      check("hold_no_drop", 64'(dropped), 64'd0);
      check("hold_done_high", 64'(done), 64'd1);
      check("hold_result", {c0, c1}, e);
      release_starts(e);

      // Both starts: cipher wins; address order 0,1,2,3 then decipher 2,3,0,1
      blk = {$urandom, $urandom};
      e   = tea_enc(blk);
      start_op(1'b1, 1'b1, blk, e);
      check_addr_seq(0);
      wait_done();
      release_starts(e);
      e = tea_dec(blk);
      start_op(1'b0, 1'b1, blk, e);
      check_addr_seq(2);
      wait_done();
      release_starts(e);

      // Reset in round 10 aborts; next op completes
      blk = {$urandom, $urandom};
      start_op(1'b1, 1'b0, blk, tea_enc(blk));
      repeat (40) @(negedge clk);
      rst     = 1'b1;
      start_c = 1'b0;
      @(negedge clk);
      check("abort_c", {c0, c1}, 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_addr", 64'(key_addr), 64'd0);
      check("abort_state", 64'(fsm_state), 64'(ST_IDLE));
      rst = 1'b0;
      void'(exp_q.pop_back());
      void'(exp_cyc_q.pop_back());
      repeat (2) @(negedge clk);
      blk = {$urandom, $urandom};
      run_op(1'b0, 1'b1, blk, tea_dec(blk));

      // Randomized keys, blocks and modes
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < 4; i++) key_mem[i] = $urandom;
         blk = {$urandom, $urandom};
         sc  = 1'($urandom_range(0, 1));
         e   = sc ? tea_enc(blk) : tea_dec(blk);
         run_op(sc, !sc, blk, e);
      end

      repeat (3) @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
